// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Serialises up to two writeback register writes per cycle onto the single
//   register-file write port, in program order. Writes that cannot issue this
//   cycle are held in a small FIFO of DEPTH entries. The pipeline is stalled
//   via halt_out when the FIFO is nearly full, and decode can forward values
//   that are still waiting to be written through the lookup port.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   we1/tgt1/data1      write request, port 1 (older in program order)
//   we2/tgt2/data2      write request, port 2 (younger in program order)
//   halt_out            stall request; requests are ignored while high
//   rf_we/rf_tgt/rf_data registered register-file write port
//   count               registered number of buffered entries
//   lk_tgt              lookup register number
//   lk_hit/lk_data      combinational lookup result (youngest pending value)
//
// Handshake: a request on port N is accepted in a cycle when weN=1, tgtN!=0
// and halt_out=0 at the rising edge; there is no per-port ready, halt_out is
// the only backpressure and an accepted request is never dropped.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we1,
  input  logic [4:0]    tgt1,
  input  logic [31:0]   data1,
  input  logic          we2,
  input  logic [4:0]    tgt2,
  input  logic [31:0]   data2,
  output logic          halt_out,
  output logic          rf_we,
  output logic [4:0]    rf_tgt,
  output logic [31:0]   rf_data,
  output logic [CW-1:0] count,
  input  logic [4:0]    lk_tgt,
  output logic          lk_hit,
  output logic [31:0]   lk_data
);

  localparam int PW = $clog2(DEPTH);

  logic [4:0]    ent_tgt_q  [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_we_q;
  logic [4:0]    rf_tgt_q;
  logic [31:0]   rf_data_q;

  logic          v1, v2, keep1, pop;
  logic          issue_en;
  logic [4:0]    issue_tgt;
  logic [31:0]   issue_data;
  logic          push0_en, push1_en;
  logic [4:0]    push0_tgt, push1_tgt;
  logic [31:0]   push0_data, push1_data;
  logic [PW-1:0] wr_ptr_p1;

  assign halt_out = (count_q >= CW'(DEPTH - 1));

  always_comb begin
    v1    = we1 && !halt_out && (tgt1 != 5'd0);
    v2    = we2 && !halt_out && (tgt2 != 5'd0);
    // Same target on both ports: port 2 is younger, so port 1 is redundant.
    keep1 = v1 && !(v2 && (tgt1 == tgt2));
    pop   = (count_q != '0);

    // Oldest candidate issues: FIFO head, else port 1, else port 2.
    issue_en   = pop || keep1 || v2;
    issue_tgt  = tgt2;
    issue_data = data2;
    if (pop) begin
      issue_tgt  = ent_tgt_q[rd_ptr_q];
      issue_data = ent_data_q[rd_ptr_q];
    end else if (keep1) begin
      issue_tgt  = tgt1;
      issue_data = data1;
    end

    // Everything that did not issue is appended in program order.
    push0_en   = 1'b0;
    push0_tgt  = tgt2;
    push0_data = data2;
    push1_en   = 1'b0;
    push1_tgt  = tgt2;
    push1_data = data2;
    if (pop) begin
      if (keep1) begin
        push0_en   = 1'b1;
        push0_tgt  = tgt1;
        push0_data = data1;
        push1_en   = v2;
      end else begin
        push0_en = v2;
      end
    end else begin
      push0_en = keep1 && v2;
    end

    wr_ptr_p1 = wr_ptr_q + PW'(1);
    wr_ptr_d  = wr_ptr_q + PW'(push0_en) + PW'(push1_en);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(push0_en) + CW'(push1_en) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rf_we_q   <= 1'b0;
      rf_tgt_q  <= 5'd0;
      rf_data_q <= 32'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rf_we_q  <= issue_en;
      if (issue_en) begin
        rf_tgt_q  <= issue_tgt;
        rf_data_q <= issue_data;
      end
    end
  end

  // Entry storage needs no reset: validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push0_en) begin
      ent_tgt_q[wr_ptr_q]  <= push0_tgt;
      ent_data_q[wr_ptr_q] <= push0_data;
    end
    if (push1_en) begin
      ent_tgt_q[wr_ptr_p1]  <= push1_tgt;
      ent_data_q[wr_ptr_p1] <= push1_data;
    end
  end

  // Lookup scans oldest to youngest so the youngest match overwrites; the
  // rf output register is the oldest pending write.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = 32'd0;
    if (rf_we_q && (rf_tgt_q == lk_tgt)) begin
      lk_hit  = 1'b1;
      lk_data = rf_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (ent_tgt_q[rd_ptr_q + PW'(i)] == lk_tgt)) begin
        lk_hit  = 1'b1;
        lk_data = ent_data_q[rd_ptr_q + PW'(i)];
      end
    end
    if (lk_tgt == 5'd0) begin
      lk_hit  = 1'b0;
      lk_data = 32'd0;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_tgt  = rf_tgt_q;
  assign rf_data = rf_data_q;
  assign count   = count_q;

endmodule
